tilt_averager: RTL and testbench

Upstream conditioning stage for the spirit-level LED display. Accepts raw signed 16-bit tilt samples with a valid strobe and averages them over fixed windows of 2^LOG2_N samples. Each average is presented on `data`, followed by a `latch` pulse. The display stage captures `data` on the rising edge of `latch`, so this block guarantees `data` is stable for one full cycle before `latch` rises and for the whole time `latch` is high.

---
 rtl/tilt_averager.sv | 169 ++++++++++++++++
 tb/tb_tilt_averager.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tilt_averager.sv
// tilt_averager: window averager feeding the spirit-level LED display.
//
// Accepts signed 16-bit tilt samples and averages each window of 2^LOG2_N
// samples. The average is floor-divided, so it rounds toward minus infinity.
// Each average is loaded into `data`. One cycle later `latch` rises and stays
// high for HOLD cycles. `data` is therefore stable for a full cycle before
// the rising edge of `latch` and for as long as `latch` stays high.
//
// Parameters:
//   LOG2_N  log2 of the window length (1..6), default 3 (8 samples)
//   HOLD    number of cycles `latch` stays high per strobe (>= 1)
//
// Ports:
//   clk           single clock, rising-edge active
//   rst           synchronous active-high reset
//   sample_in     signed 16-bit tilt sample
//   sample_valid  sample_in is accepted on every edge where this is high
//   data          registered signed average presented to the display
//   latch         registered capture strobe for the display
//   overrun       one-cycle pulse when an undelivered result is overwritten
//
// Build option:
//   TILT_CLAMP_EN  when defined, the value loaded into `data` is saturated
//                  to [-249, +249] so the display always lights a segment.
module tilt_averager #(
    parameter int LOG2_N = 3,
    parameter int HOLD   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] sample_in,
    input  logic               sample_valid,
    output logic signed [15:0] data,
    output logic               latch,
    output logic               overrun
);

    localparam int AW = 16 + LOG2_N;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE
    } state_t;

    state_t                 state_q, state_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [AW-1:0]   sum;
    logic [LOG2_N-1:0]      cnt_q, cnt_d;
    logic signed [15:0]     result_q, result_d;
    logic signed [15:0]     data_q, data_d;
    logic                   pending_q, pending_d;
    logic                   overrun_q, overrun_d;
    logic                   latch_q, latch_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   win_done;
    logic                   consume;

    function automatic logic signed [15:0] clamp_out(input logic signed [15:0] v);
`ifdef TILT_CLAMP_EN
        if (v > 16'sd249) begin
            return 16'sd249;
        end else if (v < -16'sd249) begin
            return -16'sd249;
        end else begin
            return v;
        end
`else
        return v;
`endif
    endfunction

    // Accumulator and sample counter run independently of the output FSM.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        sum      = acc_q + $signed({{LOG2_N{sample_in[15]}}, sample_in});
        win_done = sample_valid && (cnt_q == '1);
        if (sample_valid) begin
            if (win_done) begin
                acc_d    = '0;
                cnt_d    = '0;
                // Dropping the low LOG2_N bits of the signed sum is an
                // arithmetic right shift, i.e. floor division. The upper 16
                // bits always hold the full average.
                result_d = sum[AW-1:LOG2_N];
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + LOG2_N'(1);
            end
        end
    end

    // Output FSM: data loads in IDLE, latch rises after one SETUP cycle.
    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        hold_d  = hold_q;
        data_d  = data_q;
        consume = 1'b0;
        case (state_q)
            IDLE: begin
                latch_d = 1'b0;
                if (pending_q) begin
                    data_d  = clamp_out(result_q);
                    consume = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                latch_d = 1'b1;
                hold_d  = '0;
                state_d = STROBE;
            end
            STROBE: begin
                latch_d = 1'b1;
                if (hold_q == HOLD_LAST) begin
                    latch_d = 1'b0;
                    hold_d  = '0;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                latch_d = 1'b0;
                hold_d  = '0;
                state_d = IDLE;
            end
        endcase

        // A fresh window always wins over a same-edge consume. An overwrite
        // only counts when the older result was not delivered on this edge.
        pending_d = win_done ? 1'b1 : (consume ? 1'b0 : pending_q);
        overrun_d = win_done && pending_q && !consume;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            data_q    <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            latch_q   <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            data_q    <= data_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            latch_q   <= latch_d;
            hold_q    <= hold_d;
        end
    end

    assign data    = data_q;
    assign latch   = latch_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_tilt_averager.sv
// Directed bench for tilt_averager. One instance uses the default
// configuration (LOG2_N=3, HOLD=4). A second instance (LOG2_N=1, HOLD=6)
// produces results faster than they can be delivered.
module tb_tilt_averager;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] s_in;
    logic               s_vld;
    logic signed [15:0] data;
    logic               latch;
    logic               overrun;

    logic signed [15:0] s_in2;
    logic               s_vld2;
    logic signed [15:0] data2;
    logic               latch2;
    logic               ovr2;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef TILT_CLAMP_EN
    localparam int EXP_MIN   = -249;
    localparam int EXP_P300  = 249;
    localparam int EXP_N5000 = -249;
`else
    localparam int EXP_MIN   = -32768;
    localparam int EXP_P300  = 300;
    localparam int EXP_N5000 = -5000;
`endif

    tilt_averager #(.LOG2_N(3), .HOLD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (s_in),
        .sample_valid (s_vld),
        .data         (data),
        .latch        (latch),
        .overrun      (overrun)
    );

    tilt_averager #(.LOG2_N(1), .HOLD(6)) dut_ovr (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (s_in2),
        .sample_valid (s_vld2),
        .data         (data2),
        .latch        (latch2),
        .overrun      (ovr2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        s_in  = 16'(v);
        s_vld = 1'b1;
        step();
        s_vld = 1'b0;
    endtask

    task automatic feed(input int v, input int n);
        repeat (n) send(v);
    endtask

    task automatic send2(input int v);
        s_in2  = 16'(v);
        s_vld2 = 1'b1;
        step();
        s_vld2 = 1'b0;
    endtask

    // Wait (bounded) for the strobe, check the presented value, then wait
    // for the strobe to finish so the next test starts from IDLE.
    task automatic await_latch(input string tag, input int exp);
        int t;
        t = 0;
        while (latch !== 1'b1 && t < 30) begin
            step();
            t++;
        end
        check_eq({tag, "_rise"}, int'(latch), 1);
        check_eq(tag, int'(data), exp);
        t = 0;
        while (latch !== 1'b0 && t < 30) begin
            step();
            t++;
        end
        step();
    endtask

    initial begin
        int seen_latch;
        int viol;
        int extra_ovr;
        logic signed [15:0] prev;

        rst    = 1'b1;
        s_in   = '0;
        s_vld  = 1'b0;
        s_in2  = '0;
        s_vld2 = 1'b0;

        // Reset values
        step();
        step();
        check_eq("rst_data", int'(data), 0);
        check_eq("rst_latch", int'(latch), 0);
        check_eq("rst_overrun", int'(overrun), 0);
        check_eq("rst_latch2", int'(latch2), 0);
        rst = 1'b0;
        seen_latch = 0;
        repeat (10) begin
            step();
            if (latch || latch2) seen_latch++;
        end
        check_eq("idle_no_latch", seen_latch, 0);

        // Basic average with exact cycle timing
        feed(100, 8);
        check_eq("basic_data_k", int'(data), 0);
        check_eq("basic_latch_k", int'(latch), 0);
        step();
        check_eq("basic_data_k1", int'(data), 100);
        check_eq("basic_latch_k1", int'(latch), 0);
        step();
        check_eq("basic_latch_k2", int'(latch), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("basic_hold%0d", i), int'(latch), 1);
        end
        step();
        check_eq("basic_latch_fall", int'(latch), 0);
        check_eq("basic_data_held", int'(data), 100);
        step();

        // Floor rounding and mixed signs
        feed(1, 7);
        send(0);
        await_latch("floor_pos", 0);
        feed(-1, 7);
        send(0);
        await_latch("floor_neg", -1);
        send(10); send(20); send(30); send(40);
        send(50); send(60); send(70); send(-1);
        await_latch("mixed", 34);
        feed(-32768, 8);
        await_latch("most_neg", EXP_MIN);

        // Clamp behaviour (or pass-through when compiled out)
        feed(300, 8);
        await_latch("clamp_pos", EXP_P300);
        feed(-5000, 8);
        await_latch("clamp_neg", EXP_N5000);

        // Overrun on the fast-window instance
        send2(10);
        send2(10);
        send2(20);
        check_eq("ovr_first_data", int'(data2), 10);
        send2(20);
        send2(30);
        check_eq("ovr_none_yet", int'(ovr2), 0);
        send2(30);
        check_eq("ovr_pulse", int'(ovr2), 1);
        step();
        check_eq("ovr_pulse_end", int'(ovr2), 0);
        viol = 0;
        extra_ovr = 0;
        prev = data2;
        for (int i = 0; i < 20; i++) begin
            step();
            if (latch2 && data2 !== prev) viol++;
            if (ovr2) extra_ovr++;
            prev = data2;
        end
        check_eq("ovr_newest", int'(data2), 30);
        check_eq("ovr_data_stable", viol, 0);
        check_eq("ovr_single_pulse", extra_ovr, 0);

        // Reset in the middle of a strobe with a partial window in flight
        feed(50, 8);
        feed(1000, 3);
        check_eq("mid_strobe_active", int'(latch), 1);
        rst = 1'b1;
        step();
        check_eq("mid_rst_latch", int'(latch), 0);
        check_eq("mid_rst_data", int'(data), 0);
        check_eq("mid_rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        step();
        feed(40, 8);
        await_latch("after_reset", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
